// File: rtl/fetch_unit_pkg.sv
// Core-wide constants shared by the core top and the fetch front-end:
// instruction width, default boot address and the canonical NOP.
package rv_defs;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch front-end bus bundle: redirect input, instruction-memory request and
// response channels, and the decode-side instruction handshake.
interface fetch_unit_if import rv_defs::*; #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = rv_defs::INSTR_WIDTH
);

  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [PC_WIDTH-1:0]    imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic [PC_WIDTH-1:0]    instr_pc_plus4;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc, instr_pc_plus4,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc, instr_pc_plus4,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous circular FIFO with flush; flush beats push and pop, and the
// head is read from registered storage (no write-to-head bypass).
module fetch_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap at DEPTH, so non-power-of-two depths work too.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: owns the fetch PC, issues credit-limited
// memory requests, pairs in-order responses with their PCs and buffers them.
module fetch_unit import rv_defs::*; #(
  parameter int                  PC_WIDTH        = 16,
  parameter int                  INSTR_WIDTH     = rv_defs::INSTR_WIDTH,
  parameter int                  FIFO_DEPTH      = 4,
  parameter int                  MAX_OUTSTANDING = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = PC_WIDTH'(rv_defs::RESET_PC_DEFAULT)
) (
  input logic          sysclk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = PC_WIDTH + INSTR_WIDTH;

  logic                active_q;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]       outstanding_q, outstanding_d;
  logic [OW-1:0]       discard_q, discard_d;

  logic                req_valid, req_fire;
  logic                rsp_acc, rsp_keep, pop;
  logic [FCW-1:0]      fifo_count;
  logic [EW-1:0]       fifo_head;
  logic [OW-1:0]       pcq_count;
  logic [PC_WIDTH-1:0] rsp_pc, head_pc;
  int                  credits;

  // Non-stale in-flight requests each hold a FIFO slot, so pushes never overflow.
  always_comb begin
    credits   = int'(outstanding_q) - int'(discard_q) + int'(fifo_count);
    req_valid = active_q && (int'(outstanding_q) < MAX_OUTSTANDING)
                && (credits < FIFO_DEPTH);
  end

  assign req_fire = req_valid && bus.imem_req_ready;
  assign rsp_acc  = bus.imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep = rsp_acc && (discard_q == '0) && !bus.redirect_valid;
  assign pop      = (fifo_count != '0) && bus.instr_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_acc);
    discard_d     = discard_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~PC_WIDTH'(3);
      discard_d  = outstanding_q + OW'(req_fire) - OW'(rsp_acc);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
      if (rsp_acc && (discard_q != '0)) discard_d = discard_q - OW'(1);
    end
  end

  // Register stage: the request side is gated one cycle behind reset so that
  // imem_req_valid never depends combinationally on an input.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      active_q      <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      active_q      <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(.WIDTH(PC_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_pc_queue (
    .clk_i   (sysclk),
    .rst_ni  (rst),
    .push_i  (req_fire),
    .pop_i   (rsp_acc),
    .flush_i (1'b0),
    .din_i   (fetch_pc_q),
    .count_o (pcq_count),
    .head_o  (rsp_pc)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_prefetch (
    .clk_i   (sysclk),
    .rst_ni  (rst),
    .push_i  (rsp_keep),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .din_i   ({rsp_pc, bus.imem_rsp_data}),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign head_pc            = fifo_head[EW-1:INSTR_WIDTH];
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = (fifo_count != '0);
  assign bus.instr          = (fifo_count != '0) ? fifo_head[INSTR_WIDTH-1:0]
                                                 : INSTR_WIDTH'(NOP_INSTR);
  assign bus.instr_pc       = head_pc;
  assign bus.instr_pc_plus4 = head_pc + PC_WIDTH'(4);

  a_rsp_has_request: assert property (@(posedge sysclk) disable iff (!rst)
    bus.imem_rsp_valid |-> (outstanding_q != '0));
  a_pc_queue_tracks: assert property (@(posedge sysclk) disable iff (!rst)
    pcq_count == outstanding_q);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Decoupled, parametrised instruction fetch front-end for the next-generation core, replacing the fixed `next_pc`-to-BRAM-port-A hookup. It owns the fetch PC, issues word-aligned requests to instruction memory through a valid/ready request channel, tracks in-flight requests, and buffers returned instructions in a prefetch FIFO. Decode consumes from the FIFO through a valid/ready handshake. Control flow changes (branch, jump, trap, `mret`) arrive as a single redirect that flushes the FIFO and discards stale responses.

## Interface
- `PC_WIDTH`, 16, fetch address width in bytes.
- `INSTR_WIDTH`, 32, instruction word width.
- `FIFO_DEPTH`, 4, prefetch entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2, cap on in-flight memory requests, 1..`FIFO_DEPTH`.
- `RESET_PC`, 0, fetch address after reset; word-aligned.

- `sysclk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-low.
- `redirect_valid` in 1: one-cycle pulse; restart fetch at `redirect_pc`.
- `redirect_pc` in `PC_WIDTH`: new fetch address; bits [1:0] are ignored (treated as 00).
- `imem_req_valid` out 1: request pending.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out `PC_WIDTH`: byte address, [1:0]=00.
- `imem_rsp_valid` in 1: response data valid; responses arrive in order, ≥1 cycle after acceptance.
- `imem_rsp_data` in `INSTR_WIDTH`: instruction word.
- `instr_valid` out 1: FIFO head valid.
- `instr_ready` in 1: decode consumes the head.
- `instr` out `INSTR_WIDTH`: head instruction.
- `instr_pc` out `PC_WIDTH`: address of the head instruction.
- `instr_pc_plus4` out `PC_WIDTH`: `instr_pc`+4, wrapping modulo 2^`PC_WIDTH`.

## Operation
- State: `fetch_pc`, `outstanding` (all in-flight requests), `discard` (stale in-flight requests, ≤`outstanding`), FIFO of {pc, instr}.
- Reset (`rst`=0 at an edge): `fetch_pc`=`RESET_PC`; `outstanding`, `discard`, and FIFO count=0. While `rst`=0: `imem_req_valid`=0 and `instr_valid`=0. Reset is honoured mid-transaction; responses to pre-reset requests are protocol-illegal.
- Request: `imem_req_valid` = `outstanding`<`MAX_OUTSTANDING` AND `outstanding`−`discard`+count<`FIFO_DEPTH`. It is derived from registers only, with no combinational path from any input.
- `req_fire` = valid & ready. On `req_fire`: `fetch_pc`+=4 (wraps), `outstanding`+1. `imem_req_addr`=`fetch_pc`.
- A pc queue of depth `MAX_OUTSTANDING` records the address of each fired request, for pairing with its response.
- Response with `discard`>0: dropped; `discard`−1 and `outstanding`−1. Otherwise {pc, data} is written to the FIFO and `outstanding`−1.
- A response with `outstanding`=0 is ignored and flagged by a simulation assertion.
- Dequeue: `instr_valid`=count>0. On `instr_valid`&`instr_ready` the head is popped. Push and pop may occur in the same cycle; the count is unchanged.
- Redirect (priority over everything in that cycle):
  - FIFO flushed, and any pop that cycle is void.
  - `fetch_pc`=`redirect_pc`&~3.
  - A response in that cycle is dropped.
  - `discard` = `outstanding` + `req_fire` − `rsp_valid`. Every request still in flight after the edge is stale, including one fired this cycle at the old address.
- No overflow is possible: credits reserve a FIFO slot for every non-stale in-flight request.

## Timing
- Memory with 1-cycle response, always ready, decode always ready:
  - Cycle 0 after reset release: request to `RESET_PC`.
  - Cycle 1: response.
  - Cycle 2: `instr_valid`=1.
  - Sustained throughput: 1 instr/cycle when `MAX_OUTSTANDING`≥2.
- Redirect in cycle N: first request to the new pc in N+1; `instr_valid` for it no earlier than N+3. `instr_valid`=0 in N+1.
- FIFO outputs are registered, with no response-to-output bypass.

## Structure
- Shared constants package `rv_defs` holds `INSTR_WIDTH`, `RESET_PC` default and the NOP encoding (0x00000013). The core top and `fetch_unit` both use it.
- Sub-module `fetch_fifo`: synchronous FIFO with parameters `WIDTH` and `DEPTH`, and ports push, pop, flush, count, head. Flush has priority over push and pop. Instantiated twice: as the prefetch FIFO ({pc,instr}) and as the in-flight pc queue.
- Top holds the counters, credit logic and redirect handling.

## Test plan
- Reset release, `RESET_PC`=0x0000, 1-cycle memory returning addr-tagged words, `instr_ready`=1 -> instrs at pc 0x0,0x4,0x8… one per cycle from cycle 2; `instr_pc_plus4` correct.
- `instr_ready`=0 with `FIFO_DEPTH`=4 -> exactly 4 responses buffered. `imem_req_valid` drops to 0 and stays 0; ready=1 resumes fetch with no loss or duplication.
- `MAX_OUTSTANDING`=2, memory latency 3, 2 requests in flight, redirect to 0x0102 -> both stale responses dropped. The next request goes to 0x0100, and the first delivered `instr_pc`=0x0100.
- Redirect coincident with `req_fire`, `rsp_valid` and `instr_ready` -> FIFO empty next cycle; `discard`=`outstanding`+1−1; no stale instruction is ever delivered.
- `fetch_pc`=0xFFFC, `PC_WIDTH`=16 -> the next request address is 0x0000 and `instr_pc_plus4`=0x0000.
- `rst` asserted with 2 requests outstanding and 3 FIFO entries -> `instr_valid`=0 and `imem_req_valid`=0 the following cycle. After release, the first request is to `RESET_PC`.
